// File: rtl/cpu_pkg.sv
// Shared CPU constants and the register-file dump engine state encoding.
package cpu_pkg;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam int DEPTH  = 32;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    LOAD    = 2'd1,
    PRESENT = 2'd2,
    DONE    = 2'd3
  } dump_state_e;

endpackage : cpu_pkg

// File: rtl/regfile_dump_ctrl.sv
// Dump engine: walks every register index and presents one snapshot beat
// at a time over a valid/ready handshake, then pulses dump_done once.
module regfile_dump_ctrl
  import cpu_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              dump_start,
  input  logic              dump_ready,
  input  logic [DATA_W-1:0] load_data_i,
  output logic [ADDR_W-1:0] idx_o,
  output logic              dump_valid,
  output logic [ADDR_W-1:0] dump_addr,
  output logic [DATA_W-1:0] dump_data,
  output logic              dump_busy,
  output logic              dump_done
);

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);

  dump_state_e       state_q;
  logic [ADDR_W-1:0] idx_q;
  logic              valid_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] data_q;
  logic              busy_q;
  logic              done_q;

  assign idx_o      = idx_q;
  assign dump_valid = valid_q;
  assign dump_addr  = addr_q;
  assign dump_data  = data_q;
  assign dump_busy  = busy_q;
  assign dump_done  = done_q;

  // State, index counter and registered outputs advance together on posedge.
  // NOTE: sequential state uses non-blocking (<=) so every register samples
  // the pre-edge values and the order of statements cannot change behaviour.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      valid_q <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (dump_start) begin
            idx_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= LOAD;
          end
        end
        LOAD: begin
          // Snapshot is taken here; later writes to this index do not
          // disturb the beat while it waits for the consumer.
          data_q  <= load_data_i;
          addr_q  <= idx_q;
          valid_q <= 1'b1;
          state_q <= PRESENT;
        end
        PRESENT: begin
          if (valid_q && dump_ready) begin
            valid_q <= 1'b0;
            if (idx_q == LAST_IDX) begin
              done_q  <= 1'b1;
              state_q <= DONE;
            end else begin
              idx_q   <= idx_q + 1'b1;
              state_q <= LOAD;
            end
          end
        end
        DONE: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule : regfile_dump_ctrl

// File: rtl/regfile_dump.sv
// 32 x 32 register file: falling-edge write port, two combinational read
// ports, and a sequential dump engine for debug readback.
module regfile_dump
  import cpu_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr1,
  output logic [DATA_W-1:0] rdata1,
  input  logic [ADDR_W-1:0] raddr2,
  output logic [DATA_W-1:0] rdata2,
  input  logic              dump_start,
  input  logic              dump_ready,
  output logic              dump_valid,
  output logic [ADDR_W-1:0] dump_addr,
  output logic [DATA_W-1:0] dump_data,
  output logic              dump_busy,
  output logic              dump_done
);

  // Entry 0 is never written, so it holds its reset value of zero forever.
  logic [DATA_W-1:0] regs_q [DEPTH];
  logic [ADDR_W-1:0] dump_idx;

  // Falling-edge write so the value settles on the read ports before the
  // next rising edge, where decode and the dump engine sample it.
  // NOTE: this array is cleared by reset because the CPU relies on every
  // register reading zero afterwards; most RAMs should not be reset.
  always_ff @(negedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs_q[i] <= '0;
      end
    end else if (we && (waddr != '0)) begin
      regs_q[waddr] <= wdata;
    end
  end

  // Read ports: pure muxes, no bypass from the write port.
  assign rdata1 = regs_q[raddr1];
  assign rdata2 = regs_q[raddr2];

  regfile_dump_ctrl u_ctrl (
    .clk         (clk),
    .rst         (rst),
    .dump_start  (dump_start),
    .dump_ready  (dump_ready),
    .load_data_i (regs_q[dump_idx]),
    .idx_o       (dump_idx),
    .dump_valid  (dump_valid),
    .dump_addr   (dump_addr),
    .dump_data   (dump_data),
    .dump_busy   (dump_busy),
    .dump_done   (dump_done)
  );

endmodule : regfile_dump
